spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/snn_pkg.sv | 27 ++
 rtl/aer_event_fifo.sv | 60 ++++++
 rtl/spike_aer_encoder.sv | 113 +++++++++++
 tb/tb_spike_aer_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared types, constants and helpers for the spiking-network AER blocks.
package snn_pkg;

  // Width of the saturating drop counter exported by the encoder.
  localparam int DROP_CNT_WIDTH = 16;

  // Widest event fields any encoder instance can produce (64 neurons, 32-bit time).
  localparam int AER_IDX_MAX_WIDTH = 6;
  localparam int AER_TS_MAX_WIDTH  = 32;

  // One address-event: which neuron fired and when.
  typedef struct packed {
    logic [AER_IDX_MAX_WIDTH-1:0] idx;
    logic [AER_TS_MAX_WIDTH-1:0]  ts;
  } aer_event_t;

  // Add amt to cnt, sticking at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] cnt,
    input logic [6:0]                amt
  );
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_WIDTH - 6){1'b0}}, amt};
    return sum[DROP_CNT_WIDTH] ? {DROP_CNT_WIDTH{1'b1}} : sum[DROP_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: single-clock FIFO with registered count, full and empty flags.
// The read port shows the head entry combinationally and drives zero while empty.
module aer_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push;
  logic             pop;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // Occupancy after this edge; flags are derived from it and registered.
  always_comb begin
    count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array; contents are only visible through the head pointer when non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: turns a parallel spike vector into a stream of address-events.
// Spikes collect in a pending mask; the lowest pending index is granted into an
// event FIFO each cycle the FIFO is not full. Spikes that land on an already
// pending, ungranted bit are merged and counted in a saturating drop counter.
// Build option: define AER_TIMESTAMP_EN to attach a free-running timestamp to
// every event; without it out_ts is tied to zero and no timestamp state exists.
//
// Output handshake: an event transfers on a rising edge where out_valid and
// out_ready are both high. out_valid comes from registered FIFO state only and
// never looks at out_ready; out_idx/out_ts hold steady until the transfer.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int IDX_WIDTH  = $clog2(N_NEURONS),
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_NEURONS-1:0]      spike_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_WIDTH-1:0]      out_idx,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] grant;
  logic [N_NEURONS-1:0] merges;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [6:0]           merge_cnt;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Isolate the lowest set pending bit; the registered full flag blocks grants.
  assign grant = fifo_full ? '0 : (pending & (~pending + N_NEURONS'(1)));
  assign push  = |grant;

  // A spike on a pending bit that is not leaving this cycle is folded into it.
  assign merges = spike_in & pending & ~grant;

  // Index of the lowest set pending bit (scan downwards so the lowest wins).
  always_comb begin
    grant_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = IDX_WIDTH'(i);
    end
  end

  // Number of spikes merged this cycle.
  always_comb begin
    merge_cnt = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      merge_cnt = merge_cnt + 7'(merges[i]);
    end
  end

  // Pending mask and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~grant) | spike_in;
      drop_cnt <= sat_inc(drop_cnt, merge_cnt);
    end
  end

`ifdef AER_TIMESTAMP_EN
  localparam int EW = IDX_WIDTH + TS_WIDTH;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [EW-1:0]       wr_data;
  logic [EW-1:0]       rd_data;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  assign wr_data = {grant_idx, ts_cnt};
  assign out_idx = rd_data[EW-1 -: IDX_WIDTH];
  assign out_ts  = rd_data[TS_WIDTH-1:0];
`else
  localparam int EW = IDX_WIDTH;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;

  assign wr_data = grant_idx;
  assign out_idx = rd_data;
  assign out_ts  = '0;
`endif

  aer_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: directed bench for spike_aer_encoder (8 neurons,
// 4-bit timestamps, 8-deep FIFO). Timestamp expectations apply only when the
// design is built with AER_TIMESTAMP_EN; otherwise out_ts must read zero.
module tb_spike_aer_encoder;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TW = 4;
  localparam int D  = 8;

`ifdef AER_TIMESTAMP_EN
  localparam logic [TW-1:0] TS_MASK = '1;
`else
  localparam logic [TW-1:0] TS_MASK = '0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [TW-1:0] out_ts;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference timestamp: cycles since reset release, modulo 16.
  logic [TW-1:0] tb_ts;

  spike_aer_encoder #(
    .N_NEURONS  (N),
    .IDX_WIDTH  (IW),
    .TS_WIDTH   (TW),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_ts    (out_ts),
    .drop_cnt  (drop_cnt)
  );

  // Clock and reference timestamp.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 4'd1;
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (out_ts !== 4'd0) $display("FAIL reset_ts: got %0d want 0", out_ts); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [TW-1:0] t;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && tb_ts != 4'd10; k++) step();
    n_checks++; if (tb_ts !== 4'd10) $display("FAIL single_wait_ts: got %0d want 10", tb_ts); else n_pass++;
    t = tb_ts;
    spike_in = 8'h04;
    step();
    spike_in = 8'h00;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd2) $display("FAIL single_idx: got %0d want 2", out_idx); else n_pass++;
    n_checks++; if (out_ts !== ((t + 4'd1) & TS_MASK)) $display("FAIL single_ts: got %0d want %0d", out_ts, (t + 4'd1) & TS_MASK); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_once: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [TW-1:0] t;
    logic [IW-1:0] exp_idx [3];
    exp_idx = '{3'd0, 3'd4, 3'd7};
    out_ready = 1'b1;
    t = tb_ts;
    spike_in = 8'h91;
    step();
    spike_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL simul_valid%0d: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_idx !== exp_idx[k]) $display("FAIL simul_idx%0d: got %0d want %0d", k, out_idx, exp_idx[k]); else n_pass++;
      n_checks++; if (out_ts !== ((t + TW'(k + 1)) & TS_MASK)) $display("FAIL simul_ts%0d: got %0d want %0d", k, out_ts, (t + TW'(k + 1)) & TS_MASK); else n_pass++;
    end
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL simul_end: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL simul_drop: got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] t;
    logic [TW-1:0] a;
    logic [IW-1:0] e_idx;
    logic [TW-1:0] e_ts;
    out_ready = 1'b0;
    t = tb_ts;
    spike_in = 8'hFF;
    step();
    spike_in = 8'h00;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd0) $display("FAIL bp_idx_first: got %0d want 0", out_idx); else n_pass++;
    repeat (7) step();
    n_checks++; if (out_idx !== 3'd0) $display("FAIL bp_idx_stable: got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (out_ts !== ((t + 4'd1) & TS_MASK)) $display("FAIL bp_ts_stable: got %0d want %0d", out_ts, (t + 4'd1) & TS_MASK); else n_pass++;
    // Bit 3 held for three cycles while the FIFO is full: two merges.
    spike_in = 8'h08;
    repeat (3) step();
    spike_in = 8'h00;
    n_checks++; if (drop_cnt !== 16'd2) $display("FAIL merge_drop: got %0d want 2", drop_cnt); else n_pass++;
    step();
    step();
    n_checks++; if (out_idx !== 3'd0) $display("FAIL bp_idx_hold: got %0d want 0", out_idx); else n_pass++;
    // Drain: events 0..7, then the held bit-3 event granted once space opened.
    out_ready = 1'b1;
    a = tb_ts;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        e_idx = IW'(k);
        e_ts  = (t + TW'(k + 1)) & TS_MASK;
      end else begin
        e_idx = 3'd3;
        e_ts  = (a + 4'd1) & TS_MASK;
      end
      n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid%0d: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_idx !== e_idx) $display("FAIL drain_idx%0d: got %0d want %0d", k, out_idx, e_idx); else n_pass++;
      n_checks++; if (out_ts !== e_ts) $display("FAIL drain_ts%0d: got %0d want %0d", k, out_ts, e_ts); else n_pass++;
      step();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_end: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd2) $display("FAIL drain_drop: got %0d want 2", drop_cnt); else n_pass++;
  endtask

  task automatic test_collision();
    logic [TW-1:0] t;
    out_ready = 1'b1;
    t = tb_ts;
    spike_in = 8'h08;
    step();
    step();
    spike_in = 8'h00;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL coll_valid1: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd3) $display("FAIL coll_idx1: got %0d want 3", out_idx); else n_pass++;
    n_checks++; if (out_ts !== ((t + 4'd1) & TS_MASK)) $display("FAIL coll_ts1: got %0d want %0d", out_ts, (t + 4'd1) & TS_MASK); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL coll_valid2: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd3) $display("FAIL coll_idx2: got %0d want 3", out_idx); else n_pass++;
    n_checks++; if (out_ts !== ((t + 4'd2) & TS_MASK)) $display("FAIL coll_ts2: got %0d want %0d", out_ts, (t + 4'd2) & TS_MASK); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL coll_end: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd2) $display("FAIL coll_drop: got %0d want 2", drop_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    spike_in = 8'hFF;
    step();
    spike_in = 8'h00;
    repeat (11) step();
    // Pending is empty and the FIFO full: A5 sets four bits, then merges four.
    spike_in = 8'hA5;
    step();
    step();
    n_checks++; if (drop_cnt !== 16'd6) $display("FAIL multi_merge: got %0d want 6", drop_cnt); else n_pass++;
    spike_in = 8'hFF;
    repeat (100) step();
    n_checks++; if (drop_cnt !== 16'd802) $display("FAIL merge_accum: got %0d want 802", drop_cnt); else n_pass++;
    repeat (8700) step();
    n_checks++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat: got %h want ffff", drop_cnt); else n_pass++;
    step();
    n_checks++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat_hold: got %h want ffff", drop_cnt); else n_pass++;
    spike_in = 8'h00;
    n_checks++; if (out_idx !== 3'd0) $display("FAIL sat_head: got %0d want 0", out_idx); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen_valid;
    int seen_ts;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    spike_in = 8'h1F;
    step();
    spike_in = 8'h00;
    repeat (6) step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_queued: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL mid_drop_clear: got %0d want 0", drop_cnt); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd0) $display("FAIL mid_async_idx: got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (out_ts !== 4'd0) $display("FAIL mid_async_ts: got %0d want 0", out_ts); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_valid = 0;
    seen_ts = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid !== 1'b0) seen_valid++;
      if (out_ts !== 4'd0) seen_ts++;
    end
    n_checks++; if (seen_valid !== 0) $display("FAIL mid_no_events: got %0d valid cycles want 0", seen_valid); else n_pass++;
    n_checks++; if (seen_ts !== 0) $display("FAIL mid_ts_zero: got %0d nonzero cycles want 0", seen_ts); else n_pass++;
  endtask

  task automatic test_release_sample();
    rst_n = 1'b0;
    out_ready = 1'b1;
    spike_in = 8'h02;
    step();
    rst_n = 1'b1;
    step();
    spike_in = 8'h00;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rel_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 3'd1) $display("FAIL rel_idx: got %0d want 1", out_idx); else n_pass++;
    n_checks++; if (out_ts !== (4'd1 & TS_MASK)) $display("FAIL rel_ts: got %0d want %0d", out_ts, 4'd1 & TS_MASK); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rel_end: got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_release_sample();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
